// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types, frame constants and baud divisor helper.
//   tx_state_t   : transmitter FSM states (IDLE, START, DATA, STOP)
//   FRAME_BITS   : serial bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS    : payload bits per frame
//   baud_cnt_max : system clock cycles per serial bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    function automatic int baud_cnt_max(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write request and data; ignored while full
//   pop, dout  : read request and head-of-queue data; ignored while empty
//   full, empty: derived from the registered count
//   count      : number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the count at the start of the cycle, so a push
    // while full is dropped even if a pop frees a slot on the same edge.
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them
    // wrap naturally; the count is what separates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, frames sent back to back.
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   data_in, data_in_ready : byte and one-cycle write strobe
//   overflow_clr       : clears the sticky overflow flag (a same-cycle drop wins)
//   tx                 : serial line, idles high
//   tx_busy            : high while a frame is on the line
//   fifo_count         : queued bytes, excluding the one being shifted
//   overflow           : sticky, set when a strobed byte was dropped
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_ready,
    input  logic                          overflow_clr,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
    localparam int CW           = $clog2(BAUD_CNT_MAX + 1);

    tx_state_t            state;
    tx_state_t            state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic [2:0]           idx;
    logic [2:0]           idx_n;
    logic                 pop;
    logic                 tx_n;
    logic                 busy_n;
    logic                 bit_end;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (data_in_ready),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = cnt == CW'(BAUD_CNT_MAX - 1);
    assign drop    = data_in_ready && fifo_full;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        idx_n   = idx;
        pop     = 1'b0;
        if (state != IDLE)
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end)
                    state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'(DATA_BITS - 1))
                        state_n = STOP;
                end
            end
            STOP: begin
                // A queued byte chains straight into the next start bit.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        idx_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // tx and tx_busy are registered from the next state so the line
        // changes on the same edge the FSM does.
        tx_n   = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            idx      <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            idx      <= idx_n;
            tx       <= tx_n;
            tx_busy  <= busy_n;
            overflow <= drop || (overflow && !overflow_clr);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo at 10 cycles per bit.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dv = 1'b0;
    logic       oclr = 1'b0;
    logic       tx;
    logic       busy;
    logic [3:0] cnt;
    logic       ovf;

    uart_tx_fifo #(
        .CLK_FREQ   (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (8)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .data_in       (din),
        .data_in_ready (dv),
        .overflow_clr  (oclr),
        .tx            (tx),
        .tx_busy       (busy),
        .fifo_count    (cnt),
        .overflow      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int busy_total = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (busy === 1'b1) busy_total++;

    int total = 0;
    int bad = 0;
    logic [7:0] rx_d [16];
    int         rx_t [16];
    int         rx_e [16];
    int         rx_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        din = b;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic wait_low(input int lim, output bit found);
        found = 1'b0;
        for (int i = 0; i < lim && !found; i++) begin
            if (tx === 1'b0)
                found = 1'b1;
            else
                @(negedge clk);
        end
    endtask

    task automatic rx_frames(input int n);
        bit f;
        logic [7:0] b;
        int ferr;
        rx_n = 0;
        for (int k = 0; k < n; k++) begin
            wait_low(300, f);
            if (!f) begin
                chk("rx_timeout", k, n);
                return;
            end
            rx_t[k] = cyc;
            ferr = 0;
            repeat (5) @(negedge clk);
            if (tx !== 1'b0) ferr++;
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                b[i] = tx;
            end
            repeat (10) @(negedge clk);
            if (tx !== 1'b1) ferr++;
            rx_d[k] = b;
            rx_e[k] = ferr;
            rx_n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] a5_seq;
        int errs;
        int nbusy;
        int b0;
        bit f;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte 0xA5: start, LSB-first data, stop, 10 cycles each
        a5_seq = {1'b1, 8'hA5, 1'b0};
        strobe(8'hA5);
        chk("t1_pre_tx", tx, 1);
        chk("t1_cnt", cnt, 1);
        @(negedge clk);
        errs = 0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== a5_seq[i/10]) errs++;
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        chk("t1_wave_errs", errs, 0);
        chk("t1_busy_len", nbusy, 100);
        chk("t1_end_tx", tx, 1);
        chk("t1_end_busy", busy, 0);

        // three back-to-back strobes, contiguous frames
        b0 = busy_total;
        fork
            begin
                strobe(8'h12);
                strobe(8'h34);
                chk("t2_cnt_a", cnt, 1);
                strobe(8'h56);
                chk("t2_cnt_peak", cnt, 2);
            end
            rx_frames(3);
        join
        chk("t2_rx_n", rx_n, 3);
        chk("t2_b0", rx_d[0], 8'h12);
        chk("t2_b1", rx_d[1], 8'h34);
        chk("t2_b2", rx_d[2], 8'h56);
        chk("t2_gap1", rx_t[1] - rx_t[0], 100);
        chk("t2_gap2", rx_t[2] - rx_t[1], 100);
        chk("t2_ferr", rx_e[0] + rx_e[1] + rx_e[2], 0);
        repeat (10) @(negedge clk);
        chk("t2_busy_total", busy_total - b0, 300);
        chk("t2_cnt_end", cnt, 0);

        // ten strobes into depth 8: tenth dropped; clear vs. drop priority
        fork
            begin
                for (int i = 0; i < 9; i++) strobe(8'h40 + 8'(i));
                chk("t3_cnt9", cnt, 8);
                chk("t3_ovf9", ovf, 0);
                strobe(8'h49);
                chk("t3_cnt10", cnt, 8);
                chk("t3_ovf10", ovf, 1);
                din = 8'hEE;
                dv = 1'b1;
                oclr = 1'b1;
                @(negedge clk);
                dv = 1'b0;
                chk("t4_set_wins", ovf, 1);
                @(negedge clk);
                oclr = 1'b0;
                chk("t4_clr", ovf, 0);
            end
            rx_frames(9);
        join
        chk("t3_rx_n", rx_n, 9);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t3_b%0d", k), rx_d[k], 8'h40 + 8'(k));
            chk($sformatf("t3_ferr%0d", k), rx_e[k], 0);
            if (k > 0) chk($sformatf("t3_gap%0d", k), rx_t[k] - rx_t[k-1], 100);
        end
        wait_low(60, f);
        chk("t3_no_extra", f, 0);

        // reset during data bit 3 with two bytes queued
        strobe(8'hF0);
        strobe(8'h11);
        strobe(8'h22);
        chk("t5_cnt", cnt, 2);
        repeat (42) @(negedge clk);
        chk("t5_bit3_tx", tx, 0);
        chk("t5_bit3_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_tx", tx, 1);
        chk("t5_busy", busy, 0);
        chk("t5_cnt_clr", cnt, 0);
        wait_low(150, f);
        chk("t5_no_frame", f, 0);

        // push coincident with pop at end of stop, count 1
        strobe(8'h3C);
        strobe(8'hC3);
        repeat (99) @(negedge clk);
        strobe(8'h5A);
        chk("t6_cnt", cnt, 1);
        chk("t6_tx_start", tx, 0);
        chk("t6_busy", busy, 1);
        rx_frames(2);
        chk("t6_rx_n", rx_n, 2);
        chk("t6_b0", rx_d[0], 8'hC3);
        chk("t6_b1", rx_d[1], 8'h5A);
        chk("t6_gap", rx_t[1] - rx_t[0], 100);
        chk("t6_ferr", rx_e[0] + rx_e[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
